int_square: RTL
===============

Name: int_square

Overview:
- Iterative unsigned integer squarer: result = value * value.
- Inverse counterpart of the integer square-root unit, and uses the same start/done protocol. While reset is held the operand is loaded; deasserting reset starts the computation; done marks a valid result.
- Shift-add datapath, BITS_PER_CYCLE multiplier bits consumed per clock.
- Serves as the forward operator that round-trip checks root results: isr(x)^2 <= x < (isr(x)+1)^2.

Parameters:
- IN_WIDTH, 32, operand width. Result width is 2*IN_WIDTH.
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle. Must divide IN_WIDTH; legal values 1, 2, 4, 8.

Ports:
- clock, input, 1, sole clock; all state updates on posedge.
- reset, input, 1, synchronous, active-high. Also serves as load/start: held high loads value, falling edge starts the computation.
- value, input, IN_WIDTH, unsigned operand; sampled only on posedges where reset=1.
- result, output, 2*IN_WIDTH, unsigned square; valid only when done=1.
- done, output, 1, high when result is valid; held until the next reset.

Behaviour:
- Registers: mcand (2*IN_WIDTH, operand zero-extended), mplier (IN_WIDTH), acc (2*IN_WIDTH), count (log2(IN_WIDTH/BITS_PER_CYCLE)+1 bits), state.
- States: LOAD, RUN, DONE.
- Posedge with reset=1, from any state:
  - state<=LOAD; mcand<=value; mplier<=value; acc<=0; count<=0; done<=0.
  - result may be left stale, but done=0 is guaranteed.
  - Reset is the only way to start a computation.
- LOAD, posedge with reset=0: state<=RUN and the first iteration executes on this same edge.
- Each iteration (LOAD->RUN edge and every RUN edge):
  - Partial product = mcand * mplier[BITS_PER_CYCLE-1:0], computed as a small AND/add tree.
  - acc <= acc + partial product.
  - mcand <<= BITS_PER_CYCLE.
  - mplier >>= BITS_PER_CYCLE.
  - count <= count+1.
- When the iteration making count == IN_WIDTH/BITS_PER_CYCLE completes: state<=DONE, done<=1.
  - Latency: done rises on the Nth posedge with reset low, N = IN_WIDTH/BITS_PER_CYCLE (32 for defaults).
- DONE: all registers hold; done stays 1 and result stays stable until reset.
- result is driven directly from acc (no output register stage).
- Arithmetic is exact. Max result (2^IN_WIDTH-1)^2 fits in 2*IN_WIDTH bits; the accumulator never overflows.
- value changes while reset=0 are ignored; the computation uses the operand latched on the last reset-high edge.
- Reset mid-RUN: computation aborts; done=0 and restart from LOAD on the next edge.
- Reset asserted while in DONE: done drops on that same edge.
- Reset held for multiple cycles: the last sampled value is used.
- X on value while reset=0 must not propagate into the result.

Optional Feature:
- Macro: INT_SQUARE_EARLY_EXIT_EN.
- Defined:
  - After each iteration, if the post-shift mplier == 0, go to DONE with done<=1 on that edge.
  - Latency = max(1, ceil(msb_index(value)+1 / BITS_PER_CYCLE)) cycles; value 0 or 1 completes in 1 cycle.
  - result is identical to the undefined case.
- Undefined: fixed latency of IN_WIDTH/BITS_PER_CYCLE cycles for every operand.
- Benches must wait on done, never on a cycle count.

Test Plan:
- value=9, reset high one cycle then low -> done=1 exactly 32 posedges later with result=81; done stays 1 and result stays 81 for 5 further cycles.
- value=11, then value=16'hFFFF (separate runs) -> result=121, then result=32'hFFFE0001.
- value=32'hFFFF_FFFF -> result=64'hFFFF_FFFE_0000_0001; value=0 -> result=0.
- Start value=258, toggle value to 7 during RUN, assert reset at cycle 10 with value=3 -> done never rises for the aborted run; after restart done rises with result=9.
- 100 random 32-bit values, each checked against value*value computed in the bench, plus round trip: feed the square of a random x to the ISR unit and require output == x. Repeat with BITS_PER_CYCLE=4: 8-cycle latency, same results.
- With INT_SQUARE_EARLY_EXIT_EN: value=1 -> done after 1 cycle with result=1; value=255 -> done after 8 cycles with result=65025; value=32'h8000_0000 -> done after 32 cycles with result=64'h4000_0000_0000_0000.

Source files
------------

// File: rtl/int_square.sv
`default_nettype none
// ============================================================================
//  Module      : int_square
//  Description : Iterative unsigned integer squarer, result = value * value.
//                Shift-add datapath retiring BITS_PER_CYCLE multiplier bits
//                per clock. reset doubles as load/start: while high the
//                operand is captured, the first low edge starts the run and
//                done flags a valid result until the next reset.
//                Optional macro INT_SQUARE_EARLY_EXIT_EN: finish as soon as
//                the remaining multiplier bits are all zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_square #(
    parameter int IN_WIDTH       = 32,
    parameter int BITS_PER_CYCLE = 1   // must divide IN_WIDTH: 1, 2, 4 or 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   value,
    output logic [2*IN_WIDTH-1:0] result,
    output logic                  done
);

    localparam int c_OUT_W = 2 * IN_WIDTH;
    localparam int c_ITERS = IN_WIDTH / BITS_PER_CYCLE;
    localparam int c_CNT_W = $clog2(c_ITERS) + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_ITERS);

    localparam logic [1:0] c_S_LOAD = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_OUT_W-1:0]  r_mcand;
    logic [IN_WIDTH-1:0] r_mplier;
    logic [c_OUT_W-1:0]  r_acc;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_done;

    logic [c_OUT_W-1:0]  w_terms [BITS_PER_CYCLE];
    logic [c_OUT_W-1:0]  w_pp;
    logic [IN_WIDTH-1:0] w_mplier_next;
    logic [c_CNT_W-1:0]  w_count_next;
    logic                w_iterate;
    logic                w_last;

    // One gated, pre-shifted copy of the multiplicand per retired multiplier bit.
    generate
        for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_pp_term
            assign w_terms[j] = (r_mcand << j) & {c_OUT_W{r_mplier[j]}};
        end
    endgenerate

    // Sum the gated terms into this cycle's partial product.
    always_comb begin
        w_pp = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            w_pp = w_pp + w_terms[k];
        end
    end

    assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;
    assign w_count_next  = r_count + c_CNT_ONE;
    assign w_iterate     = (r_state == c_S_LOAD) || (r_state == c_S_RUN);

`ifdef INT_SQUARE_EARLY_EXIT_EN
    // Once the shifted-out multiplier is empty no further term can be added;
    // the count limit still bounds the run as a backstop.
    assign w_last = (w_mplier_next == '0) || (w_count_next == c_CNT_LAST);
`else
    assign w_last = (w_count_next == c_CNT_LAST);
`endif

    // State register; reset always returns to LOAD.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: LOAD and RUN both execute an iteration; the final one lands in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_LOAD: w_state_next = w_last ? c_S_DONE : c_S_RUN;
            c_S_RUN:  w_state_next = w_last ? c_S_DONE : c_S_RUN;
            c_S_DONE: w_state_next = c_S_DONE;
            default:  w_state_next = c_S_LOAD;
        endcase
    end

    // Datapath: capture the operand under reset, otherwise shift-add per iteration.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mcand  <= {{IN_WIDTH{1'b0}}, value};
            r_mplier <= value;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (w_iterate) begin
            r_acc    <= r_acc + w_pp;
            r_mcand  <= r_mcand << BITS_PER_CYCLE;
            r_mplier <= w_mplier_next;
            r_count  <= w_count_next;
        end
    end

    // done rises with the final iteration and holds until the next reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_done <= 1'b0;
        end else if (w_iterate && w_last) begin
            r_done <= 1'b1;
        end
    end

    assign result = r_acc;
    assign done   = r_done;

endmodule
`default_nettype wire
